imem_stream_loader: RTL and testbench

- Boot-time program loader feeding the single-cycle core's instruction memory from a byte stream, instead of preloading a hex file.
- Receives a framed byte stream over valid/ready: 16-bit word count, little-endian instruction words, then an XOR checksum byte.
- Writes one 32-bit word per instruction-memory write and holds the core in reset until the image is verified.
- Sits between a host link (UART/JTAG bridge or bench driver) and the IMEM write port.

---
 rtl/imem_stream_loader.sv | 136 +++++++++++++
 tb/tb_imem_stream_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - framed byte-stream loader for the instruction memory
// Holds the core in reset until a checksum-verified image has been written.
module imem_stream_loader #(
  parameter int IMEM_SIZE = 16,
  localparam int AW = $clog2(IMEM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW:0]   word_idx_q, word_idx_d;
  logic [23:0]   shift_q, shift_d;
  logic [7:0]    csum_q, csum_d;
  logic          in_ready_q, in_ready_d;
  logic          imem_we_q, imem_we_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;

  logic          accept;
  logic [15:0]   hdr_count;
  logic [31:0]   word_next;
  logic [AW:0]   word_idx_inc;

  assign accept       = in_valid & in_ready_q;
  assign hdr_count    = {in_data, count_q[7:0]};
  assign word_next    = {in_data, shift_q};
  assign word_idx_inc = word_idx_q + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_HDR0: begin
        if (accept) begin
          count_d = {count_q[15:8], in_data};
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count > 16'(IMEM_SIZE)) begin
            state_d = S_ERR;
          end else if (hdr_count == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d    = word_next[31:8];
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes a little-endian word: issue the write next cycle.
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q[AW-1:0];
            imem_wdata_d = word_next;
            word_idx_d   = word_idx_inc;
            if ({{(15-AW){1'b0}}, word_idx_inc} == count_q) begin
              state_d = S_CHK;
            end
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: ;
    endcase

    in_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                 (state_d == S_DATA) || (state_d == S_CHK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HDR0;
      count_q      <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      shift_q      <= '0;
      csum_q       <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign cpu_reset  = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - randomized bench for imem_stream_loader
// Reference model derives writes and final flags directly from the frame format.
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_stream_loader #(.IMEM_SIZE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed writes, captured away from the rising edge.
  logic [35:0] wr_q[$];
  logic        we_prev = 1'b0;
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back({imem_addr, imem_wdata});
      check_eq("we_single_cycle", 64'(we_prev), 64'(0));
    end
    we_prev = imem_we;
  end

  // Reference model: expected writes, flags and number of accepted bytes.
  logic [35:0] exp_wr[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_acc;

  task automatic model(input logic [7:0] s[$]);
    int          n;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_wr.delete();
    n = int'({s[1], s[0]});
    if (n > 16) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      exp_acc  = 2;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++) begin
        w  = w | (32'(s[2 + 4*i + b]) << (8*b));
        cs = cs ^ s[2 + 4*i + b];
      end
      exp_wr.push_back({4'(i), w});
    end
    exp_acc  = 3 + 4*n;
    exp_done = (s[2 + 4*n] == cs);
    exp_err  = !exp_done;
  endtask

  int acc;

  // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random 0..4 idle cycles.
  task automatic send(input logic [7:0] s[$], input int gap_mode);
    int g;
    int budget;
    acc = 0;
    foreach (s[k]) begin
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 4)) : 0;
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[k];
      budget = 0;
      while (!in_ready && budget < 8) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) break;
      @(posedge clk);
      acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check_eq({tag, "_imem_we"}, 64'(imem_we), 64'(0));
    check_eq({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
    check_eq({tag, "_error"}, 64'(error), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("rst");
    check_eq("rst_addr", 64'(imem_addr), 64'(0));
    check_eq("rst_wdata", 64'(imem_wdata), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_rst", 64'(in_ready), 64'(1));
    wr_q.delete();
  endtask

  task automatic run(input string tag, input logic [7:0] s[$], input int gap_mode);
    do_reset();
    model(s);
    send(s, gap_mode);
    check_eq({tag, "_done"}, 64'(done), 64'(exp_done));
    check_eq({tag, "_error"}, 64'(error), 64'(exp_err));
    check_eq({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(!exp_done));
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    repeat (3) @(negedge clk);
    check_eq({tag, "_accepted"}, 64'(acc), 64'(exp_acc));
    check_eq({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
      check_eq({tag, "_write"}, 64'(wr_q[i]), 64'(exp_wr[i]));
    end
    check_eq({tag, "_sticky"}, 64'({done, error}), 64'({exp_done, exp_err}));
  endtask

  logic [7:0] s1[$];
  logic [7:0] s[$];

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    s1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00, 8'hE1};

    run("good", s1, 0);
    check_eq("good_w0", 64'(wr_q.size() > 0 ? wr_q[0] : 36'h0), 64'({4'd0, 32'h00500093}));
    check_eq("good_w1", 64'(wr_q.size() > 1 ? wr_q[1] : 36'h0), 64'({4'd1, 32'h00300113}));

    s = s1;
    s[10] = 8'hE0;
    run("badcsum", s, 0);

    s = '{8'h11, 8'h00, 8'h93, 8'h00, 8'h50};
    run("toobig", s, 0);

    s = '{8'h00, 8'h00, 8'h00};
    run("empty_ok", s, 0);
    s = '{8'h00, 8'h00, 8'h5A};
    run("empty_bad", s, 0);

    run("alt_gap", s1, 1);
    run("rand_gap", s1, 2);

    // Reset after five bytes: no partial write, then a full clean reload.
    do_reset();
    s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50};
    send(s, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check_eq("midrst_nwrites", 64'(wr_q.size()), 64'(0));
    run("reload", s1, 0);

    for (int it = 0; it < 25; it++) begin
      int          n;
      logic [7:0]  cs;
      logic [15:0] hdr;
      s.delete();
      n = int'($urandom_range(0, 20));
      if (n > 16) begin
        hdr = ($urandom_range(0, 3) == 0) ? (16'h0100 | 16'($urandom_range(0, 255))) : 16'(n);
        s.push_back(hdr[7:0]);
        s.push_back(hdr[15:8]);
        s.push_back(8'($urandom));
        s.push_back(8'($urandom));
      end else begin
        s.push_back(8'(n));
        s.push_back(8'h00);
        cs = 8'h00;
        for (int k = 0; k < 4*n; k++) begin
          s.push_back(8'($urandom));
          cs = cs ^ s[s.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
        s.push_back(cs);
        if ($urandom_range(0, 1) == 0) s.push_back(8'($urandom));
      end
      run("random", s, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
